vx_fp_round_arbiter: RTL and testbench

Shares one rounding datapath among NUM_REQS FPU sub-units (add, mul, fma, cvt) that produce pre-rounded magnitudes. It arbitrates round-robin with valid/ready handshakes and resolves dynamic rounding mode against the frm CSR. It performs the round-up decision and increment, then registers the result with requester ID and tag. It sits between the FPU compute units and the FPU result normalisation/writeback stage.

---
 rtl/vx_fp_round_arbiter.sv | 136 +++++++++++++
 tb/tb_vx_fp_round_arbiter.sv | 318 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/vx_fp_round_arbiter.sv
// Round-robin arbiter in front of a shared FP rounding stage: picks one pre-rounded
// magnitude per cycle, applies the resolved rounding mode and registers the result.
module vx_fp_round_arbiter #(
  parameter int NUM_REQS   = 4,
  parameter int DATA_WIDTH = 32,
  parameter int TAG_WIDTH  = 8
) (
  input  logic                            clk,
  input  logic                            reset,
  input  logic [NUM_REQS-1:0]             req_valid_in,
  output logic [NUM_REQS-1:0]             req_ready_out,
  input  logic [NUM_REQS*DATA_WIDTH-1:0]  req_abs_value_in,
  input  logic [NUM_REQS-1:0]             req_sign_in,
  input  logic [2*NUM_REQS-1:0]           req_round_sticky_in,
  input  logic [3*NUM_REQS-1:0]           req_rnd_mode_in,
  input  logic [NUM_REQS-1:0]             req_eff_sub_in,
  input  logic [NUM_REQS*TAG_WIDTH-1:0]   req_tag_in,
  input  logic [2:0]                      frm_csr_in,
  output logic                            rsp_valid_out,
  input  logic                            rsp_ready_in,
  output logic [DATA_WIDTH-1:0]           rsp_value_out,
  output logic                            rsp_sign_out,
  output logic                            rsp_exact_zero_out,
  output logic                            rsp_inexact_out,
  output logic                            rsp_invalid_rm_out,
  output logic [$clog2(NUM_REQS)-1:0]     rsp_req_id_out,
  output logic [TAG_WIDTH-1:0]            rsp_tag_out
);

  localparam int ID_WIDTH = $clog2(NUM_REQS);

  localparam logic [2:0] RM_RNE = 3'b000;
  localparam logic [2:0] RM_RTZ = 3'b001;
  localparam logic [2:0] RM_RDN = 3'b010;
  localparam logic [2:0] RM_RUP = 3'b011;
  localparam logic [2:0] RM_RMM = 3'b100;
  localparam logic [2:0] RM_DYN = 3'b111;

  logic [ID_WIDTH-1:0]   ptr;
  logic [ID_WIDTH-1:0]   grant_idx;
  logic                  grant_found;
  logic                  en;
  logic                  accept;
  int                    cand;
  logic [DATA_WIDTH-1:0] sel_value;
  logic                  sel_sign;
  logic                  sel_eff_sub;
  logic [1:0]            sel_rs;
  logic [2:0]            sel_rm;
  logic [TAG_WIDTH-1:0]  sel_tag;

  logic [2:0]            rm_res;
  logic                  rm_invalid;
  logic                  round_up;
  logic [DATA_WIDTH-1:0] rounded;
  logic                  exact_zero;
  logic                  final_sign;

  // Walk from lowest to highest priority so the last hit is the winner.
  always_comb begin
    grant_found = 1'b0;
    grant_idx   = '0;
    cand        = 0;
    sel_value   = '0;
    sel_sign    = 1'b0;
    sel_eff_sub = 1'b0;
    sel_rs      = 2'b00;
    sel_rm      = 3'b000;
    sel_tag     = '0;
    for (int k = NUM_REQS; k >= 1; k--) begin
      cand = (int'(ptr) + k) % NUM_REQS;
      if (req_valid_in[cand]) begin
        grant_found = 1'b1;
        grant_idx   = cand[ID_WIDTH-1:0];
        sel_value   = req_abs_value_in[cand*DATA_WIDTH +: DATA_WIDTH];
        sel_sign    = req_sign_in[cand];
        sel_eff_sub = req_eff_sub_in[cand];
        sel_rs      = req_round_sticky_in[cand*2 +: 2];
        sel_rm      = req_rnd_mode_in[cand*3 +: 3];
        sel_tag     = req_tag_in[cand*TAG_WIDTH +: TAG_WIDTH];
      end
    end
  end

  assign en     = ~rsp_valid_out | rsp_ready_in;
  assign accept = grant_found & en & ~reset;

  always_comb begin
    req_ready_out = '0;
    if (accept) req_ready_out[grant_idx] = 1'b1;
  end

  always_comb begin
    rm_res     = (sel_rm == RM_DYN) ? frm_csr_in : sel_rm;
    rm_invalid = (rm_res == 3'b101) || (rm_res == 3'b110) || (rm_res == 3'b111);
    case (rm_res)
      RM_RNE:  round_up = sel_rs[1] & (sel_rs[0] | sel_value[0]);
      RM_RTZ:  round_up = 1'b0;
      RM_RDN:  round_up = (sel_rs[1] | sel_rs[0]) & sel_sign;
      RM_RUP:  round_up = (sel_rs[1] | sel_rs[0]) & ~sel_sign;
      RM_RMM:  round_up = sel_rs[1];
      default: round_up = 1'b0;
    endcase
    // Overflow wraps; the carry into the exponent is handled downstream.
    rounded    = sel_value + DATA_WIDTH'(round_up);
    exact_zero = (sel_value == '0) && (sel_rs == 2'b00);
    final_sign = (exact_zero & sel_eff_sub) ? (rm_res == RM_RDN) : sel_sign;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      ptr                <= ID_WIDTH'(NUM_REQS - 1);
      rsp_valid_out      <= 1'b0;
      rsp_value_out      <= '0;
      rsp_sign_out       <= 1'b0;
      rsp_exact_zero_out <= 1'b0;
      rsp_inexact_out    <= 1'b0;
      rsp_invalid_rm_out <= 1'b0;
      rsp_req_id_out     <= '0;
      rsp_tag_out        <= '0;
    end else if (accept) begin
      ptr                <= grant_idx;
      rsp_valid_out      <= 1'b1;
      rsp_value_out      <= rounded;
      rsp_sign_out       <= final_sign;
      rsp_exact_zero_out <= exact_zero;
      rsp_inexact_out    <= sel_rs[1] | sel_rs[0];
      rsp_invalid_rm_out <= rm_invalid;
      rsp_req_id_out     <= grant_idx;
      rsp_tag_out        <= sel_tag;
    end else if (rsp_ready_in) begin
      rsp_valid_out      <= 1'b0;
    end
  end

endmodule

// File: tb/tb_vx_fp_round_arbiter.sv
// Bench for vx_fp_round_arbiter: rounding vector table, round-robin / hold / reset
// sequences, and a negedge monitor with an arbitration model feeding a scoreboard.
module tb_vx_fp_round_arbiter;
  localparam int N  = 4;
  localparam int DW = 32;
  localparam int TW = 8;
  localparam int IW = 2;

  logic              clk = 1'b0;
  logic              reset;
  logic [N-1:0]      req_valid_in;
  logic [N-1:0]      req_ready_out;
  logic [N*DW-1:0]   req_abs_value_in;
  logic [N-1:0]      req_sign_in;
  logic [2*N-1:0]    req_round_sticky_in;
  logic [3*N-1:0]    req_rnd_mode_in;
  logic [N-1:0]      req_eff_sub_in;
  logic [N*TW-1:0]   req_tag_in;
  logic [2:0]        frm_csr_in;
  logic              rsp_valid_out;
  logic              rsp_ready_in;
  logic [DW-1:0]     rsp_value_out;
  logic              rsp_sign_out;
  logic              rsp_exact_zero_out;
  logic              rsp_inexact_out;
  logic              rsp_invalid_rm_out;
  logic [IW-1:0]     rsp_req_id_out;
  logic [TW-1:0]     rsp_tag_out;

  vx_fp_round_arbiter #(.NUM_REQS(N), .DATA_WIDTH(DW), .TAG_WIDTH(TW)) dut (
    .clk(clk), .reset(reset),
    .req_valid_in(req_valid_in), .req_ready_out(req_ready_out),
    .req_abs_value_in(req_abs_value_in), .req_sign_in(req_sign_in),
    .req_round_sticky_in(req_round_sticky_in), .req_rnd_mode_in(req_rnd_mode_in),
    .req_eff_sub_in(req_eff_sub_in), .req_tag_in(req_tag_in), .frm_csr_in(frm_csr_in),
    .rsp_valid_out(rsp_valid_out), .rsp_ready_in(rsp_ready_in),
    .rsp_value_out(rsp_value_out), .rsp_sign_out(rsp_sign_out),
    .rsp_exact_zero_out(rsp_exact_zero_out), .rsp_inexact_out(rsp_inexact_out),
    .rsp_invalid_rm_out(rsp_invalid_rm_out), .rsp_req_id_out(rsp_req_id_out),
    .rsp_tag_out(rsp_tag_out)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [DW-1:0] value;
    logic          sign, zero, nx, inv;
    logic [IW-1:0] id;
    logic [TW-1:0] tag;
  } rsp_t;

  typedef struct {
    int        id;
    logic [31:0] v;
    logic [1:0]  rs;
    logic [2:0]  rm, frm;
    logic        sg, es;
    logic [31:0] ev;
    logic        esg, ez, enx, einv;
  } vec_t;

  rsp_t sb_q[$];
  int   n_cmp = 0;
  int   n_bad = 0;
  int   tag_seen[256];
  logic mon_on = 1'b0;
  int   mptr = N - 1;
  logic prev_hold = 1'b0;
  rsp_t prev;

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference rounding model, evaluated from the inputs of requester i.
  function automatic rsp_t model(int i);
    rsp_t r;
    logic [DW-1:0] v;
    logic rnd, stk, sg, es, up;
    logic [2:0] rm;
    v   = req_abs_value_in[i*DW +: DW];
    rnd = req_round_sticky_in[2*i+1];
    stk = req_round_sticky_in[2*i];
    sg  = req_sign_in[i];
    es  = req_eff_sub_in[i];
    rm  = req_rnd_mode_in[3*i +: 3];
    if (rm == 3'b111) rm = frm_csr_in;
    up = 1'b0;
    r.inv = 1'b0;
    case (rm)
      3'd0: up = rnd && (stk || v[0]);
      3'd2: up = (rnd || stk) && sg;
      3'd3: up = (rnd || stk) && !sg;
      3'd4: up = rnd;
      3'd5, 3'd6, 3'd7: r.inv = 1'b1;
      default: up = 1'b0;
    endcase
    r.value = v + DW'(up);
    r.zero  = (v == '0) && !rnd && !stk;
    r.sign  = (r.zero && es) ? (rm == 3'b010) : sg;
    r.nx    = rnd | stk;
    r.id    = IW'(i);
    r.tag   = req_tag_in[i*TW +: TW];
    return r;
  endfunction

  always @(negedge clk) begin
    if (mon_on) begin
      logic [N-1:0] exp_rdy;
      rsp_t e;
      #1;
      if (prev_hold) begin
        check("hold_valid", 32'(rsp_valid_out), 32'd1);
        check("hold_value", rsp_value_out, prev.value);
        check("hold_tag", 32'(rsp_tag_out), 32'(prev.tag));
        check("hold_id", 32'(rsp_req_id_out), 32'(prev.id));
      end
      if (rsp_valid_out) begin
        if (sb_q.size() == 0) begin
          n_cmp++; n_bad++;
          $display("FAIL sb_unexpected: got response tag 0x%0h expected none", rsp_tag_out);
        end else begin
          e = sb_q[0];
          check("sb_value", rsp_value_out, e.value);
          check("sb_sign", 32'(rsp_sign_out), 32'(e.sign));
          check("sb_zero", 32'(rsp_exact_zero_out), 32'(e.zero));
          check("sb_nx", 32'(rsp_inexact_out), 32'(e.nx));
          check("sb_inv", 32'(rsp_invalid_rm_out), 32'(e.inv));
          check("sb_id", 32'(rsp_req_id_out), 32'(e.id));
          check("sb_tag", 32'(rsp_tag_out), 32'(e.tag));
          if (rsp_ready_in) begin
            void'(sb_q.pop_front());
            tag_seen[rsp_tag_out]++;
          end
        end
      end
      prev_hold  = rsp_valid_out && !rsp_ready_in && !reset;
      prev.value = rsp_value_out;
      prev.tag   = rsp_tag_out;
      prev.id    = rsp_req_id_out;
      exp_rdy = '0;
      if (reset) begin
        mptr = N - 1;
        sb_q.delete();
      end else if (!rsp_valid_out || rsp_ready_in) begin
        for (int k = 1; k <= N; k++) begin
          int c;
          c = (mptr + k) % N;
          if (req_valid_in[c]) begin
            exp_rdy[c] = 1'b1;
            sb_q.push_back(model(c));
            mptr = c;
            break;
          end
        end
      end
      check("ready", 32'(req_ready_out), 32'(exp_rdy));
    end
  end

  task automatic clear_reqs();
    req_valid_in        = '0;
    req_abs_value_in    = '0;
    req_sign_in         = '0;
    req_round_sticky_in = '0;
    req_rnd_mode_in     = '0;
    req_eff_sub_in      = '0;
    req_tag_in          = '0;
  endtask

  task automatic set_req(int i, logic [DW-1:0] v, logic [1:0] rs, logic [2:0] rm,
                         logic sg, logic es, logic [TW-1:0] tg);
    req_valid_in[i]               = 1'b1;
    req_abs_value_in[i*DW +: DW]  = v;
    req_round_sticky_in[2*i +: 2] = rs;
    req_rnd_mode_in[3*i +: 3]     = rm;
    req_sign_in[i]                = sg;
    req_eff_sub_in[i]             = es;
    req_tag_in[i*TW +: TW]        = tg;
  endtask

  vec_t vt[19];

  initial begin
    logic [N-1:0] done_m;
    int first_g;
    logic [TW-1:0] held_tag;

    vt[0]  = '{1, 32'h5,        2'b10, 3'd0, 3'd0, 1'b0, 1'b0, 32'h6,  1'b0, 1'b0, 1'b1, 1'b0};
    vt[1]  = '{1, 32'h4,        2'b10, 3'd0, 3'd0, 1'b0, 1'b0, 32'h4,  1'b0, 1'b0, 1'b1, 1'b0};
    vt[2]  = '{0, 32'h10,       2'b01, 3'd7, 3'd2, 1'b1, 1'b0, 32'h11, 1'b1, 1'b0, 1'b1, 1'b0};
    vt[3]  = '{0, 32'h10,       2'b01, 3'd7, 3'd5, 1'b1, 1'b0, 32'h10, 1'b1, 1'b0, 1'b1, 1'b1};
    vt[4]  = '{2, 32'h0,        2'b00, 3'd2, 3'd0, 1'b0, 1'b1, 32'h0,  1'b1, 1'b1, 1'b0, 1'b0};
    vt[5]  = '{2, 32'h0,        2'b00, 3'd0, 3'd0, 1'b0, 1'b1, 32'h0,  1'b0, 1'b1, 1'b0, 1'b0};
    vt[6]  = '{3, 32'hFFFFFFFF, 2'b11, 3'd0, 3'd0, 1'b0, 1'b0, 32'h0,  1'b0, 1'b0, 1'b1, 1'b0};
    vt[7]  = '{3, 32'h7,        2'b11, 3'd1, 3'd0, 1'b0, 1'b0, 32'h7,  1'b0, 1'b0, 1'b1, 1'b0};
    vt[8]  = '{3, 32'h8,        2'b10, 3'd4, 3'd0, 1'b1, 1'b0, 32'h9,  1'b1, 1'b0, 1'b1, 1'b0};
    vt[9]  = '{1, 32'h8,        2'b01, 3'd3, 3'd0, 1'b1, 1'b0, 32'h8,  1'b1, 1'b0, 1'b1, 1'b0};
    vt[10] = '{1, 32'h8,        2'b01, 3'd3, 3'd0, 1'b0, 1'b0, 32'h9,  1'b0, 1'b0, 1'b1, 1'b0};
    vt[11] = '{0, 32'h3,        2'b11, 3'd2, 3'd0, 1'b0, 1'b0, 32'h3,  1'b0, 1'b0, 1'b1, 1'b0};
    vt[12] = '{0, 32'h3,        2'b11, 3'd6, 3'd0, 1'b0, 1'b0, 32'h3,  1'b0, 1'b0, 1'b1, 1'b1};
    vt[13] = '{2, 32'h7,        2'b10, 3'd0, 3'd0, 1'b0, 1'b0, 32'h8,  1'b0, 1'b0, 1'b1, 1'b0};
    vt[14] = '{2, 32'h7,        2'b01, 3'd0, 3'd0, 1'b0, 1'b0, 32'h7,  1'b0, 1'b0, 1'b1, 1'b0};
    vt[15] = '{1, 32'h6,        2'b10, 3'd7, 3'd7, 1'b0, 1'b0, 32'h6,  1'b0, 1'b0, 1'b1, 1'b1};
    vt[16] = '{3, 32'h0,        2'b10, 3'd4, 3'd0, 1'b1, 1'b1, 32'h1,  1'b1, 1'b0, 1'b1, 1'b0};
    vt[17] = '{0, 32'h0,        2'b00, 3'd7, 3'd2, 1'b0, 1'b1, 32'h0,  1'b1, 1'b1, 1'b0, 1'b0};
    vt[18] = '{2, 32'h0,        2'b00, 3'd0, 3'd0, 1'b1, 1'b0, 32'h0,  1'b1, 1'b1, 1'b0, 1'b0};

    for (int i = 0; i < 256; i++) tag_seen[i] = 0;
    reset = 1'b1;
    clear_reqs();
    rsp_ready_in = 1'b1;
    frm_csr_in = 3'b000;
    repeat (2) @(negedge clk);
    set_req(1, 32'h1, 2'b00, 3'd0, 1'b0, 1'b0, 8'h77);
    mon_on = 1'b1;
    @(negedge clk);
    #2;
    check("rst_ready", 32'(req_ready_out), 32'd0);
    check("rst_valid", 32'(rsp_valid_out), 32'd0);
    check("rst_value", rsp_value_out, 32'd0);
    check("rst_tag", 32'(rsp_tag_out), 32'd0);
    check("rst_id", 32'(rsp_req_id_out), 32'd0);

    // Requesters 0 and 2 held valid: grants alternate starting with 0.
    @(negedge clk);
    reset = 1'b0;
    clear_reqs();
    set_req(0, 32'h20, 2'b00, 3'd0, 1'b0, 1'b0, 8'hA0);
    set_req(2, 32'h22, 2'b00, 3'd0, 1'b0, 1'b0, 8'hA2);
    for (int j = 0; j < 4; j++) begin
      @(negedge clk);
      check("rr_valid", 32'(rsp_valid_out), 32'd1);
      check("rr_id", 32'(rsp_req_id_out), (j % 2 == 0) ? 32'd0 : 32'd2);
    end
    clear_reqs();
    @(negedge clk);

    for (int t = 0; t < 19; t++) begin
      @(negedge clk);
      clear_reqs();
      set_req(vt[t].id, vt[t].v, vt[t].rs, vt[t].rm, vt[t].sg, vt[t].es, 8'(16 + t));
      frm_csr_in = vt[t].frm;
      rsp_ready_in = 1'b1;
      @(negedge clk);
      clear_reqs();
      check("vec_valid", 32'(rsp_valid_out), 32'd1);
      check("vec_value", rsp_value_out, vt[t].ev);
      check("vec_sign", 32'(rsp_sign_out), 32'(vt[t].esg));
      check("vec_zero", 32'(rsp_exact_zero_out), 32'(vt[t].ez));
      check("vec_nx", 32'(rsp_inexact_out), 32'(vt[t].enx));
      check("vec_inv", 32'(rsp_invalid_rm_out), 32'(vt[t].einv));
      check("vec_id", 32'(rsp_req_id_out), 32'(vt[t].id));
      check("vec_tag", 32'(rsp_tag_out), 32'(16 + t));
    end
    frm_csr_in = 3'b000;

    // All four valid, downstream stalls for three cycles, then releases.
    @(negedge clk);
    done_m = '0;
    first_g = -1;
    held_tag = '0;
    for (int i = 0; i < N; i++) set_req(i, 32'(256 + i), 2'b00, 3'd0, 1'b0, 1'b0, 8'(64 + i));
    for (int c = 0; c < 40; c++) begin
      if (c > 0) @(negedge clk);
      rsp_ready_in = (c >= 1 && c <= 3) ? 1'b0 : 1'b1;
      for (int i = 0; i < N; i++) if (done_m[i]) req_valid_in[i] = 1'b0;
      #2;
      if (c >= 1 && c <= 3) check("stall_ready", 32'(req_ready_out), 32'd0);
      if (c == 1) held_tag = rsp_tag_out;
      if (c >= 2 && c <= 4) check("stall_tag", 32'(rsp_tag_out), 32'(held_tag));
      for (int i = 0; i < N; i++) begin
        if (req_ready_out[i]) begin
          done_m[i] = 1'b1;
          if (c == 0) first_g = i;
          if (c == 4) check("release_next", 32'(i), 32'((first_g + 1) % N));
        end
      end
      if (done_m == '1) break;
    end
    check("stall_all_granted", 32'(done_m), 32'hF);
    @(negedge clk);
    clear_reqs();
    repeat (3) @(negedge clk);
    for (int i = 0; i < N; i++) check("stall_tag_once", 32'(tag_seen[64 + i]), 32'd1);

    // Reset while a response is pending.
    @(negedge clk);
    set_req(3, 32'hFFFFFFFF, 2'b11, 3'd0, 1'b0, 1'b0, 8'h50);
    rsp_ready_in = 1'b0;
    @(negedge clk);
    clear_reqs();
    check("pre_rst_valid", 32'(rsp_valid_out), 32'd1);
    check("pre_rst_wrap", rsp_value_out, 32'd0);
    check("pre_rst_zero", 32'(rsp_exact_zero_out), 32'd0);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check("mid_rst_valid", 32'(rsp_valid_out), 32'd0);
    check("mid_rst_tag", 32'(rsp_tag_out), 32'd0);
    for (int i = 0; i < N; i++) set_req(i, 32'(512 + i), 2'b00, 3'd0, 1'b0, 1'b0, 8'(96 + i));
    rsp_ready_in = 1'b1;
    @(negedge clk);
    clear_reqs();
    check("post_rst_id", 32'(rsp_req_id_out), 32'd0);
    check("post_rst_tag", 32'(rsp_tag_out), 32'h60);
    repeat (3) @(negedge clk);
    check("sb_drained", 32'(sb_q.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
